// File: rtl/tiny_nn_conv_seq.sv
// Command-driven 1D convolution sequencer that streams weight/window terms into a shared fp MAC.
// Optional NaN tracking is built only when TINY_NN_NAN_CHECK_EN is defined.
module tiny_nn_conv_seq #(
    parameter int MaxKernel      = 16,
    parameter int MaxOutstanding = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [15:0] mac_a_o,
    output logic [15:0] mac_b_o,
    output logic        mac_valid_o,
    output logic        mac_first_o,
    output logic        mac_last_o,
    input  logic [15:0] mac_result_i,
    input  logic        mac_result_valid_i,
    output logic [15:0] out_o,
    output logic        out_valid_o,
    output logic        busy_o,
    output logic        err_cmd_o,
    output logic        err_nan_o
);

    typedef logic [15:0] fp_t;

    localparam int IW = (MaxKernel > 1) ? $clog2(MaxKernel) : 1;
    localparam int OW = $clog2(MaxOutstanding + 1);

    localparam logic [3:0] CmdOpConvolve = 4'h1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_W = 3'd1;
    localparam logic [2:0] FILL   = 3'd2;
    localparam logic [2:0] STREAM = 3'd3;
    localparam logic [2:0] MAC    = 3'd4;
    localparam logic [2:0] DRAIN  = 3'd5;

    logic [2:0]    state;
    logic          started;
    logic [IW-1:0] k_m1;
    logic [IW-1:0] idx;
    logic [7:0]    l_m1;
    logic [7:0]    out_cnt;
    logic [OW-1:0] outstanding;
    fp_t           w   [MaxKernel];
    fp_t           win [MaxKernel];

    fp_t  out_q;
    logic out_valid_q;
    logic err_cmd_q;

    logic xfer;
    logic cmd_ok;
    logic term_last;
    logic res_accept;
    fp_t  res_data;

    assign xfer       = data_valid_i && data_ready_o;
    assign cmd_ok     = (data_i[15:12] == CmdOpConvolve) &&
                        ({1'b0, data_i[3:0]} <= 5'(MaxKernel - 1));
    assign term_last  = (state == MAC) && (idx == k_m1);
    assign res_accept = mac_result_valid_i && (outstanding != '0);

    // Ready is held off until the first cycle after reset is released.
    always_comb begin
        data_ready_o = 1'b0;
        if (started) begin
            case (state)
                IDLE, LOAD_W, FILL: data_ready_o = 1'b1;
                STREAM:             data_ready_o = (outstanding != OW'(MaxOutstanding));
                default:            data_ready_o = 1'b0;
            endcase
        end
    end

    assign mac_valid_o = (state == MAC);
    assign mac_a_o     = mac_valid_o ? w[idx]   : '0;
    assign mac_b_o     = mac_valid_o ? win[idx] : '0;
    assign mac_first_o = mac_valid_o && (idx == '0);
    assign mac_last_o  = term_last;

    assign out_o     = out_q;
    assign out_valid_o = out_valid_q;
    assign err_cmd_o = err_cmd_q;
    assign busy_o    = (state != IDLE) || (outstanding != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            started <= 1'b0;
            k_m1    <= '0;
            idx     <= '0;
            l_m1    <= '0;
            out_cnt <= '0;
            for (int i = 0; i < MaxKernel; i++) begin
                w[i]   <= '0;
                win[i] <= '0;
            end
        end else begin
            started <= 1'b1;
            case (state)
                IDLE: begin
                    if (xfer && cmd_ok) begin
                        k_m1    <= data_i[IW-1:0];
                        l_m1    <= data_i[11:4];
                        idx     <= '0;
                        out_cnt <= '0;
                        state   <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (xfer) begin
                        w[idx] <= data_i;
                        if (idx == k_m1) begin
                            idx   <= '0;
                            state <= (k_m1 == '0) ? STREAM : FILL;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (xfer) begin
                        win[idx] <= data_i;
                        if (idx == k_m1 - 1'b1) begin
                            idx   <= '0;
                            state <= STREAM;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        win[k_m1] <= data_i;
                        idx       <= '0;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    if (term_last) begin
                        // Slide the window so the next value lands in slot K-1.
                        for (int i = 0; i < MaxKernel - 1; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[MaxKernel-1] <= '0;
                        idx <= '0;
                        if (out_cnt == l_m1) begin
                            state <= DRAIN;
                        end else begin
                            out_cnt <= out_cnt + 8'd1;
                            state   <= STREAM;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Results arriving with nothing outstanding are stale and dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_cmd_q   <= 1'b0;
        end else begin
            case ({term_last, res_accept})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            out_valid_q <= res_accept;
            if (res_accept) begin
                out_q <= res_data;
            end
            err_cmd_q <= (state == IDLE) && xfer && !cmd_ok;
        end
    end

`ifdef TINY_NN_NAN_CHECK_EN
    localparam fp_t FPStdNaN = 16'hFFFF;
    localparam int  PW       = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    function automatic logic is_nan(input fp_t x);
        return ((x[14:7] == 8'h00) && ((x[6:0] != 7'h00) || x[15])) ||
               ((x[14:7] == 8'hFF) && (x[6:0] != 7'h00));
    endfunction

    logic [MaxKernel-1:0]      w_nan;
    logic [MaxKernel-1:0]      win_nan;
    logic [MaxOutstanding-1:0] nan_fifo;
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic                      nan_acc;
    logic                      nan_sticky;
    logic                      in_nan;
    logic                      term_nan;

    assign in_nan    = is_nan(data_i);
    assign term_nan  = w_nan[idx] | win_nan[idx] | ((idx != '0) & nan_acc);
    assign res_data  = nan_fifo[rd_ptr] ? FPStdNaN : mac_result_i;
    assign err_nan_o = nan_sticky;

    // NaN flags follow the same slots as the data; one flag per issued output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_nan      <= '0;
            win_nan    <= '0;
            nan_fifo   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            nan_acc    <= 1'b0;
            nan_sticky <= 1'b0;
        end else begin
            if (xfer && (state != IDLE)) begin
                nan_sticky <= nan_sticky | in_nan;
                case (state)
                    LOAD_W:  w_nan[idx]     <= in_nan;
                    FILL:    win_nan[idx]   <= in_nan;
                    STREAM:  win_nan[k_m1]  <= in_nan;
                    default: ;
                endcase
            end
            if (state == MAC) begin
                nan_acc <= term_nan;
                if (term_last) begin
                    nan_fifo[wr_ptr] <= term_nan;
                    wr_ptr  <= (wr_ptr == PW'(MaxOutstanding - 1)) ? '0 : wr_ptr + 1'b1;
                    win_nan <= win_nan >> 1;
                end
            end
            if (res_accept) begin
                rd_ptr <= (rd_ptr == PW'(MaxOutstanding - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end
`else
    assign res_data  = mac_result_i;
    assign err_nan_o = 1'b0;
`endif

endmodule

// File: doc/tiny_nn_conv_seq.md
# tiny_nn_conv_seq

Command-driven sequencer that runs a 1D convolution on the shared floating-point multiply-accumulate (MAC) unit. It parses a command word, loads a kernel of up to 16 weights, and buffers a sliding window of input values. For each output it issues one MAC term per weight, then forwards the MAC results to the output port. It sits between the host-facing word stream and the MAC datapath; all operands are `fp_t` from `tiny_nn_pkg` (1 sign, 8 exponent, 7 mantissa bits).

## Interface
Parameters:
- `MaxKernel`, default 16: weight/window storage depth; power of 2, at most 16.
- `MaxOutstanding`, default 4: maximum number of MAC results issued but not yet returned; at least 1.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `data_i`  in  16  command word, weight or value (`fp_t`).
- `data_valid_i`  in  1  `data_i` valid.
- `data_ready_o`  out  1  block accepts `data_i`; a transfer occurs when valid and ready are both high.
- `mac_a_o`  out  16  MAC operand A (weight).
- `mac_b_o`  out  16  MAC operand B (window value).
- `mac_valid_o`  out  1  the term on `mac_a_o`/`mac_b_o` is valid this cycle.
- `mac_first_o`  out  1  first term of an output; the MAC sets its accumulator to a*b.
- `mac_last_o`  out  1  last term of an output; the MAC returns a result later.
- `mac_result_i`  in  16  accumulated result.
- `mac_result_valid_i`  in  1  `mac_result_i` valid; single-cycle pulse, arbitrary latency, results return in issue order.
- `out_o`  out  16  convolution output.
- `out_valid_o`  out  1  `out_o` valid; single-cycle pulse, no backpressure.
- `busy_o`  out  1  state is not IDLE, or results are still outstanding.
- `err_cmd_o`  out  1  one-cycle pulse when a command is rejected.
- `err_nan_o`  out  1  sticky NaN flag (see Configuration).

## Operation
Command decode, on a transfer in IDLE:
- `op` = `data_i[15:12]`, kernel size `K` = `data_i[3:0]`+1, output count `L` = `data_i[11:4]`+1.
- The command is accepted when `op` == `CmdOpConvolve` and `K` <= `MaxKernel`; the block goes to LOAD_W.
- Any other command is consumed, `err_cmd_o` pulses for one cycle, and the block stays in IDLE.

States:
- IDLE: wait for a command.
- LOAD_W: accept `K` words into `w[0..K-1]` in arrival order, then go to FILL, or straight to STREAM when `K`=1.
- FILL: accept `K-1` values into window slots `win[0..K-2]`, then go to STREAM.
- STREAM: accept one value into `win[K-1]`, then go to MAC. `data_ready_o` is low while outstanding == `MaxOutstanding`.
- MAC: for `K` consecutive cycles, term i drives `mac_a_o`=`w[i]`, `mac_b_o`=`win[i]` and `mac_valid_o`=1. `mac_first_o` is high at i=0 and `mac_last_o` at i=K-1 (both high when `K`=1).
  - After the last term the window shifts by one (`win[i]` <= `win[i+1]`) and the issued-output count increments.
  - If `L` outputs have been issued, go to DRAIN; otherwise return to STREAM.
- DRAIN: wait until outstanding == 0, then go to IDLE.

Result handling:
- Output j = sum over i of `w[i]`*`x[j+i]`.
- The outstanding counter increments on `mac_last_o` and decrements on `mac_result_valid_i`; when both occur in the same cycle it is unchanged.
- A `mac_result_valid_i` pulse that arrives while outstanding == 0 is ignored: no output, counter stays at 0.
- Each accepted result is registered: `out_o` <= `mac_result_i` and `out_valid_o` <= 1 on the following cycle.

`data_ready_o` is high in IDLE, LOAD_W and FILL, and in STREAM subject to the outstanding limit above. It is low in MAC and DRAIN.

## Timing
- Reset values: `data_ready_o`=0, all MAC outputs 0, `out_o`=0, `out_valid_o`=0, `busy_o`=0, `err_cmd_o`=0, `err_nan_o`=0. After reset: state IDLE, counters 0, `w` and `win` cleared to 0.
- `data_ready_o` goes high the cycle after reset is released.
- Latency from a value transfer in STREAM to the first MAC term is 1 cycle. The term stream lasts `K` cycles, so steady-state throughput is one output per `K`+1 cycles.
- Latency from `mac_result_valid_i` to `out_valid_o` is 1 cycle.
- Reset asserted mid-operation abandons the command immediately. MAC results already in flight are then discarded, because outstanding is 0 after reset.
- `busy_o` drops in the same cycle the block returns to IDLE.

## Configuration
- Macro: `TINY_NN_NAN_CHECK_EN`.
- Defined:
  - Every accepted weight and value is checked with `is_nan`; a word with exponent 0 and (mantissa != 0 or sign = 1) counts as NaN, as does exponent all-ones with mantissa != 0.
  - Each window slot and each weight carries a NaN bit.
  - When a term stream uses any NaN operand, a flag is pushed into a `MaxOutstanding`-deep FIFO. The FIFO is popped on each accepted result, and a flagged result is replaced by `FPStdNaN` (0xFFFF) on `out_o`.
  - `err_nan_o` sets on any NaN accepted and clears only on reset.
  - The MAC terms are still issued unchanged.
- Undefined: no checks or FIFO are built, `err_nan_o` is tied to 0, and results pass through unmodified.

## Test plan
- Basic convolution, with a behavioural MAC of 3-cycle latency:
  - Stimulus: command 0x1011 (`K`=2, `L`=2), weights 0x3F80, 0x4000, values 0x3F80, 0x4000, 0x4040.
  - Required response: terms (0x3F80,0x3F80), (0x4000,0x4000), then (0x3F80,0x4000), (0x4000,0x4040); outputs 0x40A0 then 0x4100; `busy_o` low after the second output.
- Bad command:
  - Stimulus: 0x2005, then 0x1003 with `MaxKernel`=2.
  - Required response: `err_cmd_o` pulses once per command, the block stays in IDLE, no MAC activity.
- `K`=1 with `L`=3:
  - Stimulus: command 0x1020, weight 0x4000, values 0x3F80, 0x3F00, 0x4040.
  - Required response: each term has `mac_first_o` and `mac_last_o` both high; outputs 0x4000, 0x3F80, 0x40C0.
- Backpressure, with `MaxOutstanding`=1 and MAC latency 5:
  - Required response: `data_ready_o` stays low in STREAM until each result returns, and outstanding never exceeds 1.
- Reset mid-MAC:
  - Stimulus: assert `rst_i` during the term stream; a MAC result arrives afterwards.
  - Required response: all outputs are at their reset values, and the late result produces no `out_valid_o`.
- NaN path, with `TINY_NN_NAN_CHECK_EN` defined:
  - Stimulus: the basic scenario with value 0x8000 in place of the second value.
  - Required response: both outputs are 0xFFFF and `err_nan_o` stays high. With the macro undefined, the raw MAC results are passed through.
